// File: rtl/mips_pkg.sv
// Shared MIPS core constants: datapath widths, the hardwired zero register and the
// writeback source encoding.
package mips_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      SelAlu = 1'b0,
      SelMem = 1'b1
   } wbSel_e;

endpackage

// File: rtl/wb_select.sv
// Writeback source mux: picks load data or the ALU result. The forwarding unit uses it too.
module wb_select
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_to_reg,
   output logic [DATA_W-1:0] wb_data
);

   always_comb begin
      wb_data = alu_data;
      if (wbSel_e'(mem_to_reg) == SelMem) begin
         wb_data = mem_data;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB consumer: commits the writeback bundle to the register file and serves the decode
// read ports (write-first bypass), a debug read port and a committed-write counter.
module wb_regfile
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = mips_pkg::DATA_W,
   parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              le,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_valid,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] RegZero = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] regsQ [Depth];
   logic [CNT_W-1:0]  wrCountQ;
   logic [DATA_W-1:0] wbData;
   logic              wbValid;

   wb_select #(
      .DATA_W(DATA_W)
   ) uWbSelect (
      .mem_data  (mem_data),
      .alu_data  (alu_data),
      .mem_to_reg(mem_to_reg),
      .wb_data   (wbData)
   );

   // Gating on reg_write first keeps an unknown mem_to_reg from reaching the array.
   always_comb begin
      wbValid = 1'b0;
      if (!reset && le && reg_write && (write_reg != RegZero)) begin
         wbValid = 1'b1;
      end
   end

   function automatic logic [DATA_W-1:0] readPort(
      input logic [ADDR_W-1:0] addr,
      input logic              bypass
   );
      logic [DATA_W-1:0] val;
      val = '0;
      if (!reset && (addr != RegZero)) begin
         if (bypass && wbValid && (addr == write_reg)) begin
            val = wbData;
         end else begin
            val = regsQ[addr];
         end
      end
      return val;
   endfunction

   always_comb begin
      rs_data  = readPort(rs_addr, 1'b1);
      rt_data  = readPort(rt_addr, 1'b1);
      dbg_data = readPort(dbg_addr, 1'b0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(Depth); i++) begin
            regsQ[i] <= '0;
         end
         wrCountQ <= '0;
      end else if (wbValid) begin
         regsQ[write_reg] <= wbData;
         wrCountQ         <= wrCountQ + CNT_W'(1);
      end
   end

   assign wb_data  = wbData;
   assign wb_valid = wbValid;
   assign wr_count = wrCountQ;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for commit/bypass/stall, plus hand sequences
// for reset-during-write and counter wrap (counter built 4 bits wide).
module tb_wb_regfile;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          le;
   logic [DW-1:0] mem_data, alu_data;
   logic [AW-1:0] write_reg, rs_addr, rt_addr, dbg_addr;
   logic          reg_write, mem_to_reg;
   logic [DW-1:0] rs_data, rt_data, wb_data, dbg_data;
   logic          wb_valid;
   logic [CW-1:0] wr_count;

   int total = 0;
   int bad   = 0;

   wb_regfile #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .le        (le),
      .mem_data  (mem_data),
      .alu_data  (alu_data),
      .write_reg (write_reg),
      .reg_write (reg_write),
      .mem_to_reg(mem_to_reg),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .wb_data   (wb_data),
      .wb_valid  (wb_valid),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          le;
      logic          rw;
      logic          m2r;
      logic [AW-1:0] wr;
      logic [DW-1:0] mem;
      logic [DW-1:0] alu;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] dbg;
      logic [DW-1:0] eRs;
      logic [DW-1:0] eRt;
      logic [DW-1:0] eDbg;
      logic [DW-1:0] eWb;
      logic          eValid;
      logic [CW-1:0] eCnt;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l, input logic rw, input logic m2r, input logic [AW-1:0] wr,
                        input logic [DW-1:0] mem, input logic [DW-1:0] alu,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] dbg);
      le = l; reg_write = rw; mem_to_reg = m2r; write_reg = wr;
      mem_data = mem; alu_data = alu; rs_addr = rs; rt_addr = rt; dbg_addr = dbg;
   endtask

   initial begin
      // {le, rw, m2r, wr, mem, alu, rs, rt, dbg, eRs, eRt, eDbg, eWb, eValid, eCnt}
      vecs[0] = '{1, 1, 0, 5,  32'h0, 32'h1234_5678, 5, 5, 5,
                  32'h1234_5678, 32'h1234_5678, 32'h0, 32'h1234_5678, 1, 0};
      vecs[1] = '{0, 0, 0, 0,  32'h0, 32'h0, 0, 0, 5,
                  32'h0, 32'h0, 32'h1234_5678, 32'h0, 0, 1};
      vecs[2] = '{1, 1, 1, 0,  32'hDEAD_BEEF, 32'h1, 0, 0, 0,
                  32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 1};
      vecs[3] = '{0, 0, 0, 0,  32'h0, 32'h0, 0, 5, 0,
                  32'h0, 32'h1234_5678, 32'h0, 32'h0, 0, 1};
      vecs[4] = '{1, 1, 1, 31, 32'hDEAD_BEEF, 32'h1, 31, 5, 31,
                  32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'hDEAD_BEEF, 1, 1};
      vecs[5] = '{0, 1, 0, 7,  32'h0, 32'hAAAA_AAAA, 31, 7, 31,
                  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'hAAAA_AAAA, 0, 2};
      vecs[6] = '{0, 0, 0, 0,  32'h0, 32'h0, 7, 7, 7,
                  32'h0, 32'h0, 32'h0, 32'h0, 0, 2};
      vecs[7] = '{1, 0, 1, 7,  32'h0BAD_0BAD, 32'h1111, 7, 7, 7,
                  32'h0, 32'h0, 32'h0, 32'h0BAD_0BAD, 0, 2};
      vecs[8] = '{0, 0, 0, 0,  32'h0, 32'h0, 7, 31, 7,
                  32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 2};

      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;

      for (int a = 0; a < 32; a++) begin
         drive(0, 0, 0, 0, 0, 0, AW'(a), AW'(31 - a), AW'(a));
         #1;
         if (rs_data != 0 || rt_data != 0 || dbg_data != 0) begin
            check("reset_read", rs_data | rt_data | dbg_data, 32'h0);
         end
      end
      total++;
      check("reset_rs5", rs_data, 32'h0);
      check("reset_cnt", DW'(wr_count), 32'h0);
      check("reset_valid", DW'(wb_valid), 32'h0);

      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].le, vecs[i].rw, vecs[i].m2r, vecs[i].wr, vecs[i].mem, vecs[i].alu,
               vecs[i].rs, vecs[i].rt, vecs[i].dbg);
         #1;
         check($sformatf("v%0d_rs", i), rs_data, vecs[i].eRs);
         check($sformatf("v%0d_rt", i), rt_data, vecs[i].eRt);
         check($sformatf("v%0d_dbg", i), dbg_data, vecs[i].eDbg);
         check($sformatf("v%0d_wb", i), wb_data, vecs[i].eWb);
         check($sformatf("v%0d_valid", i), DW'(wb_valid), DW'(vecs[i].eValid));
         check($sformatf("v%0d_cnt", i), DW'(wr_count), DW'(vecs[i].eCnt));
         tick();
      end

      // Reset arriving together with a write: the write is dropped, everything clears.
      drive(1, 1, 0, 9, 0, 32'h55, 0, 0, 9);
      tick();
      drive(0, 0, 0, 0, 0, 0, 9, 9, 9);
      #1;
      check("r9_written", dbg_data, 32'h55);
      check("cnt_before_rst", DW'(wr_count), 32'h3);
      drive(1, 1, 0, 10, 0, 32'h66, 9, 10, 9);
      reset = 1'b1;
      #1;
      check("rst_rs_forced", rs_data, 32'h0);
      check("rst_rt_forced", rt_data, 32'h0);
      check("rst_dbg_forced", dbg_data, 32'h0);
      check("rst_wb_data", wb_data, 32'h66);
      check("rst_valid", DW'(wb_valid), 32'h0);
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 9, 10, 10);
      #1;
      check("post_rst_r9", rs_data, 32'h0);
      check("post_rst_r10", rt_data, 32'h0);
      check("post_rst_cnt", DW'(wr_count), 32'h0);

      // Counter wrap: 15 commits reach all-ones, the 16th wraps to zero.
      for (int i = 1; i <= 15; i++) begin
         drive(1, 1, 0, 1, 0, DW'(i), 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
      #1;
      check("cnt_max", DW'(wr_count), 32'hF);
      check("r1_last", dbg_data, 32'hF);
      drive(1, 1, 1, 2, 32'h77, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 2);
      #1;
      check("cnt_wrap", DW'(wr_count), 32'h0);
      check("r2_after_wrap", dbg_data, 32'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register in the MIPS core: takes the registered writeback bundle and commits it to the architectural register file.
  - Bundle: memory data, ALU data, destination register, RegWrite, MemtoReg.
- Provides the decode stage's two read ports, with write-first bypass.
- Provides a debug read port and a committed-write counter for the debug unit.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- le  input  1  writeback stage enable; 0 = stall, no commit
- mem_data  input  DATA_W  load data from MEM/WB
- alu_data  input  DATA_W  ALU result from MEM/WB
- write_reg  input  ADDR_W  destination register index
- reg_write  input  1  write request
- mem_to_reg  input  1  1 = write mem_data, 0 = write alu_data
- rs_addr  input  ADDR_W  read port A index
- rt_addr  input  ADDR_W  read port B index
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- wb_data  output  DATA_W  selected writeback value, for EX forwarding
- wb_valid  output  1  a commit happens at the next edge
- dbg_addr  input  ADDR_W  debug read index
- dbg_data  output  DATA_W  debug read data, no bypass
- wr_count  output  CNT_W  number of committed writes

Behaviour:
- wb_data = mem_to_reg ? mem_data : alu_data. This output is combinational.
- wb_valid = !reset && le && reg_write && (write_reg != 0). This output is combinational.
- Commit: at each rising edge where wb_valid=1, regs[write_reg] <= wb_data and wr_count <= wr_count + 1.
  - Write latency: one edge.
- Register 0 is hardwired to zero.
  - Writes to index 0 are dropped and are not counted.
  - Reads of index 0 return 0 on every port.
- Reads (rs, rt) are combinational, with write-first bypass:
  - If wb_valid and addr == write_reg, return wb_data.
  - Otherwise return regs[addr].
  - The bypass closes the same-cycle WB→ID hazard, so no extra stall is needed.
- dbg_data = regs[dbg_addr]. No bypass: it shows committed state only.
- Stall: le=0 suppresses both commit and bypass; the array holds its contents.
- Reset: at any rising edge with reset=1:
  - all 2**ADDR_W registers clear to 0;
  - wr_count clears to 0;
  - any concurrent write is dropped (reset has priority over le and reg_write).
- While reset=1, rs_data, rt_data and dbg_data are forced to 0. wb_data still reflects its inputs.
- Reset values after the first reset edge: every register is 0, wr_count=0, wb_valid=0.
- wr_count wraps from 2**CNT_W-1 to 0 with no saturation and no flag.
- rs_addr == rt_addr == write_reg with wb_valid=1: both ports return wb_data.
- X on mem_to_reg while reg_write=0 must not corrupt the array.

Decomposition:
- Shared package (mips_pkg): DATA_W, ADDR_W, REG_ZERO = 0, ALU/MEM select encoding for mem_to_reg.
- One natural sub-module: wb_select, the combinational mem/alu mux producing wb_data. It is reused by the forwarding unit.
- The array, the bypass logic and the counter stay in wb_regfile.

Test Plan:
- Reset then read all 32 indexes on rs, rt and dbg → all 0; wr_count=0.
- le=1, reg_write=1, mem_to_reg=0, alu_data=0x1234_5678, write_reg=5, rs_addr=5 in the same cycle:
  - rs_data=0x1234_5678 via bypass, before the edge;
  - after the edge dbg_addr=5 → 0x1234_5678 and wr_count=1.
- mem_to_reg=1, mem_data=0xDEAD_BEEF, alu_data=0x1, write_reg=0 → r0 reads 0 and wr_count is unchanged.
  - Then write_reg=31: r31=0xDEAD_BEEF.
- le=0, reg_write=1, write_reg=7, alu_data=0xAAAA_AAAA:
  - rt_addr=7 returns the old value 0 (no bypass, no commit);
  - wr_count is unchanged.
- Write r9=0x55, then assert reset in the same cycle as a write r10=0x66:
  - after the edge r9=0 and r10=0, wr_count=0;
  - rs_data=0 while reset is high.
- Preload wr_count to 2**CNT_W-1 (force or CNT_W=4 build) and commit one write → wr_count=0.
